// File: rtl/gmux_sel_seq.sv
// Glitch-safe select sequencer for a global clock mux.
// Gates the downstream clock around every IS0 change and falls back to the pad clock.
module gmux_sel_seq #(
    parameter int QUIESCE_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter bit AUTO_FAILOVER  = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    input  logic IC_OK,
    output logic IS0,
    output logic GATE_EN,
    output logic BUSY,
    output logic DONE,
    output logic ERR,
    output logic FAIL
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GATE_OFF = 2'd1;
    localparam logic [1:0] ST_SETTLE   = 2'd2;
    localparam logic [1:0] ST_GATE_ON  = 2'd3;

    localparam logic [7:0] QUIESCE_LOAD = 8'(QUIESCE_CYCLES);
    localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       ic_ok_m;
    logic       ic_ok_s;
    logic       failover;

    logic fo_pending;
    logic accept;
    logic noop;
    logic reject;
    logic cnt_last;
    logic abort;

    // Internal clock lost while it is still selected
    assign fo_pending = AUTO_FAILOVER && IS0 && !ic_ok_s;

    assign REQ_READY = (state == ST_IDLE) && !fo_pending;
    assign accept    = REQ_VALID && REQ_READY;
    assign noop      = accept && (REQ_SEL == IS0);
    assign reject    = accept && !noop && REQ_SEL && !ic_ok_s;
    assign cnt_last  = (cnt <= 8'd1);

    // IS0 has not toggled yet in GATE_OFF, so IS0=0 means the target is IC
    assign abort = (state == ST_GATE_OFF) && !IS0 && !ic_ok_s;

    // Two-flop synchronizer for the asynchronous health status
    always_ff @(posedge CLK) begin
        if (RST) begin
            ic_ok_m <= 1'b0;
            ic_ok_s <= 1'b0;
        end else begin
            ic_ok_m <= IC_OK;
            ic_ok_s <= ic_ok_m;
        end
    end

    // Switch sequencer: quiesce the gate, move the select, settle, re-enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            IS0      <= 1'b0;
            GATE_EN  <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            FAIL     <= 1'b0;
            failover <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (state == ST_IDLE && fo_pending) begin
                        state    <= ST_GATE_OFF;
                        cnt      <= QUIESCE_LOAD;
                        GATE_EN  <= 1'b0;
                        BUSY     <= 1'b1;
                        FAIL     <= 1'b1;
                        failover <= 1'b1;
                    end else if (accept) begin
                        FAIL <= 1'b0;
                        if (noop) begin
                            DONE <= 1'b1;
                        end else if (reject) begin
                            ERR <= 1'b1;
                        end else begin
                            state    <= ST_GATE_OFF;
                            cnt      <= QUIESCE_LOAD;
                            GATE_EN  <= 1'b0;
                            BUSY     <= 1'b1;
                            failover <= 1'b0;
                        end
                    end
                end
                ST_GATE_OFF: begin
                    if (abort) begin
                        state   <= ST_GATE_ON;
                        cnt     <= 8'd0;
                        GATE_EN <= 1'b1;
                        BUSY    <= 1'b0;
                        ERR     <= 1'b1;
                    end else if (cnt_last) begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LOAD;
                        IS0   <= ~IS0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_last) begin
                        state   <= ST_GATE_ON;
                        cnt     <= 8'd0;
                        GATE_EN <= 1'b1;
                        BUSY    <= 1'b0;
                        DONE    <= !failover;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_GATE_ON: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmux_sel_seq.sv
// Bench for gmux_sel_seq: timeline model plus directed and random stimulus.
// Directed steps pin the model with hand-computed literal values.
module tb_gmux_sel_seq;

    localparam int Q = 4;
    localparam int S = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel = 1'b0;
    logic ic_ok = 1'b1;
    logic req_ready, is0, gate_en, busy, done, err, fail;

    int n_cmp = 0;
    int n_bad = 0;

    gmux_sel_seq #(
        .QUIESCE_CYCLES(Q),
        .SETTLE_CYCLES(S),
        .AUTO_FAILOVER(1'b1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .REQ_VALID(req_valid),
        .REQ_SEL(req_sel),
        .REQ_READY(req_ready),
        .IC_OK(ic_ok),
        .IS0(is0),
        .GATE_EN(gate_en),
        .BUSY(busy),
        .DONE(done),
        .ERR(err),
        .FAIL(fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Timeline model: a switch is described by its start edge number;
    // every output follows from edge arithmetic against that start.
    int   n = 0;
    bit   m_live = 0;
    logic m_s1, m_s2, m_is0, m_gate, m_busy, m_done, m_err;
    logic m_fail, m_ready, m_act, m_fo, m_tgt, m_rst_edge;
    int   m_t0, m_end, m_idle;

    always @(posedge clk) begin
        logic ics;
        logic was_idle;
        ics = m_s2;
        was_idle = !m_act;
        n++;
        m_done = 0;
        m_err = 0;
        m_rst_edge = rst;
        if (rst) begin
            m_live = 1;
            m_s1 = 0; m_s2 = 0;
            m_is0 = 0; m_gate = 1; m_busy = 0;
            m_fail = 0; m_act = 0; m_fo = 0; m_tgt = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = ic_ok;
            if (m_act) begin
                if (n == m_idle) begin
                    m_act = 0;
                end else if (m_tgt && !ics && n <= m_t0 + Q && n < m_end) begin
                    m_end = n;
                    m_idle = n + 1;
                    m_gate = 1;
                    m_busy = 0;
                    m_err = 1;
                end else if (n == m_t0 + Q) begin
                    m_is0 = ~m_is0;
                end else if (n == m_end) begin
                    m_gate = 1;
                    m_busy = 0;
                    m_done = !m_fo;
                end
            end
            if (was_idle) begin
                if (m_is0 && !ics) begin
                    m_act = 1; m_t0 = n; m_end = n + Q + S; m_idle = m_end + 1;
                    m_gate = 0; m_busy = 1; m_tgt = ~m_is0; m_fo = 1; m_fail = 1;
                end else if (req_valid) begin
                    m_fail = 0;
                    if (req_sel == m_is0) m_done = 1;
                    else if (req_sel && !ics) m_err = 1;
                    else begin
                        m_act = 1; m_t0 = n; m_end = n + Q + S; m_idle = m_end + 1;
                        m_gate = 0; m_busy = 1; m_tgt = ~m_is0; m_fo = 0;
                    end
                end
            end
        end
        m_ready = !m_act && !(m_is0 && !m_s2);
    end

    logic p_is0 = 1'b0;
    logic p_gate = 1'b1;
    logic p_busy = 1'b0;
    int   brun = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("is0", is0, m_is0);
            chk("gate_en", gate_en, m_gate);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("fail", fail, m_fail);
            chk("req_ready", req_ready, m_ready);
            chk("done_err_excl", done & err, 0);
            if (!m_rst_edge && is0 !== p_is0) chk("gate_at_is0_edge", p_gate, 0);
            if (busy) begin
                brun++;
            end else begin
                if (p_busy && !m_rst_edge && !err) chk("busy_len", brun, Q + S);
                brun = 0;
            end
            p_is0 = is0;
            p_gate = gate_en;
            p_busy = busy;
        end
    end

    initial begin
        @(negedge clk);
        tick(2);
        chk("rst_is0", is0, 0);
        chk("rst_gate", gate_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fail", fail, 0);
        rst = 0;
        tick(3);
        chk("ready_idle", req_ready, 1);

        // Switch to IC with defaults
        req_valid = 1; req_sel = 1;
        tick();
        req_valid = 0;
        chk("e0_gate", gate_en, 0);
        chk("e0_busy", busy, 1);
        tick(3);
        chk("e3_is0", is0, 0);
        tick();
        chk("e4_is0", is0, 1);
        tick(7);
        chk("e11_gate", gate_en, 0);
        tick();
        chk("e12_gate", gate_en, 1);
        chk("e12_done", done, 1);
        chk("e12_busy", busy, 0);
        tick();
        chk("e13_ready", req_ready, 1);
        chk("e13_done", done, 0);

        // Same-source request on IC, then back to pad
        req_valid = 1; req_sel = 1;
        tick();
        req_valid = 0;
        chk("noop1_done", done, 1);
        chk("noop1_gate", gate_en, 1);
        req_valid = 1; req_sel = 0;
        tick();
        req_valid = 0;
        tick(12);
        chk("back_is0", is0, 0);
        chk("back_done", done, 1);
        tick();

        // Same-source request on pad
        req_valid = 1; req_sel = 0;
        tick();
        req_valid = 0;
        chk("noop0_done", done, 1);
        chk("noop0_gate", gate_en, 1);
        tick();
        chk("noop0_clear", done, 0);

        // Reject while IC is unhealthy
        ic_ok = 0;
        tick(3);
        req_valid = 1; req_sel = 1;
        tick();
        req_valid = 0;
        chk("rej_err", err, 1);
        chk("rej_is0", is0, 0);
        chk("rej_gate", gate_en, 1);
        tick();
        chk("rej_err_clear", err, 0);
        ic_ok = 1;
        tick(3);

        // Failover from IC
        req_valid = 1; req_sel = 1;
        tick(13);
        req_valid = 0;
        chk("fo_pre_is0", is0, 1);
        ic_ok = 0;
        tick(2);
        req_valid = 1; req_sel = 0;
        chk("fo_not_ready", req_ready, 0);
        tick();
        chk("fo_gate", gate_en, 0);
        chk("fo_fail", fail, 1);
        tick(3);
        chk("fo_f5_is0", is0, 1);
        tick();
        chk("fo_f6_is0", is0, 0);
        tick(8);
        req_valid = 0;
        chk("fo_no_done", done, 0);
        chk("fo_gate_back", gate_en, 1);
        tick();
        chk("fo_fail_sticky", fail, 1);
        ic_ok = 1;
        tick(3);
        req_valid = 1; req_sel = 0;
        tick();
        req_valid = 0;
        chk("fail_clear", fail, 0);

        // IC lost mid-switch
        req_valid = 1; req_sel = 1;
        tick();
        req_valid = 0;
        ic_ok = 0;
        tick(3);
        chk("abort_err", err, 1);
        chk("abort_gate", gate_en, 1);
        chk("abort_busy", busy, 0);
        chk("abort_is0", is0, 0);
        tick();
        chk("abort_ready", req_ready, 1);
        ic_ok = 1;
        tick(3);

        // Reset mid-SETTLE
        req_valid = 1; req_sel = 1;
        tick();
        req_valid = 0;
        tick(4);
        chk("mid_is0", is0, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_is0", is0, 0);
        chk("mrst_gate", gate_en, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 1);
        tick(3);

        // Random traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom % 2);
            req_sel = 1'($urandom % 2);
            if ($urandom % 25 == 0) ic_ok = ~ic_ok;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gmux_sel_seq.md
GMUX_SEL_SEQ -- requirements
Module: gmux_sel_seq

Interface
REQ-001 Parameter QUIESCE_CYCLES, default 4: cycles GATE_EN stays low before IS0 changes; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles after the IS0 change before GATE_EN returns high; legal range 1..255.
REQ-003 Parameter AUTO_FAILOVER, default 1: 1 = automatic return to the pad clock when the internal clock is lost.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ_VALID  input  1  switch request valid.
REQ-007 REQ_SEL  input  1  requested source: 0 = pad clock (IP), 1 = internal clock (IC).
REQ-008 REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are high at a rising edge.
REQ-009 IC_OK  input  1  asynchronous internal-clock-healthy status.
REQ-010 IS0  output  1  registered select driving the global clock mux select pin.
REQ-011 GATE_EN  output  1  registered enable for the downstream clock gate.
REQ-012 BUSY  output  1  switch sequence in progress.
REQ-013 DONE  output  1  one-cycle pulse when a requested switch completes.
REQ-014 ERR  output  1  one-cycle pulse when a request is rejected or aborted.
REQ-015 FAIL  output  1  sticky failover flag.

Function
REQ-016 IC_OK shall pass through a 2-flop synchronizer; all logic shall use only the synchronized value ic_ok_s.
REQ-017 States: IDLE, GATE_OFF, SETTLE, GATE_ON; an 8-bit down-counter times the GATE_OFF and SETTLE states.
REQ-018 REQ_READY shall be combinational: high only in IDLE with no failover pending.
REQ-019 Accept with REQ_SEL == IS0: no gating or state change; DONE pulses at the next edge.
REQ-020 Accept with REQ_SEL = 1 and ic_ok_s = 0: request rejected; ERR pulses at the next edge; IS0 and GATE_EN unchanged.
REQ-021 Any other accept at edge E0 shall enter GATE_OFF: GATE_EN=0 and BUSY=1 from E0; counter loaded with QUIESCE_CYCLES.
REQ-022 GATE_OFF to SETTLE at edge E0+QUIESCE_CYCLES: IS0 toggles at that edge; counter loaded with SETTLE_CYCLES.
REQ-023 SETTLE to GATE_ON at edge E0+QUIESCE_CYCLES+SETTLE_CYCLES: GATE_EN=1, BUSY=0, DONE=1 at that edge.
REQ-024 GATE_ON shall last exactly one cycle and then return to IDLE; DONE shall clear at that transition.
REQ-025 Mid-switch IC loss: if the target is IC and ic_ok_s falls during GATE_OFF, go to GATE_ON without toggling IS0; ERR pulses instead of DONE.
REQ-026 Failover trigger: in IDLE with IS0=1, ic_ok_s=0 and AUTO_FAILOVER=1, run the REQ-021..024 sequence toward IS0=0.
REQ-027 During failover: set FAIL, pulse no DONE; failover has priority over a REQ_VALID in the same cycle.
REQ-028 FAIL shall clear at the next accepted request of any kind.
REQ-029 REQ_VALID while not ready shall be ignored; the block keeps no request queue.
REQ-030 GATE_EN shall never be high at an edge where IS0 changes.
REQ-031 DONE and ERR shall never be high in the same cycle.

Reset
REQ-032 RST high at an edge shall force, at that edge: state=IDLE, counter=0, synchronizer=0, IS0=0, GATE_EN=1, BUSY=0, DONE=0, ERR=0, FAIL=0.
REQ-033 RST shall override any in-progress sequence, including an IS0=1 state reached mid-SETTLE.

Verification
REQ-034 Defaults, IC_OK=1, request REQ_SEL=1 accepted at E0 -> GATE_EN=0 at E0; IS0=1 at E4; GATE_EN=1 and DONE=1 at E12; REQ_READY=1 at E13.
REQ-035 Request REQ_SEL=0 while IS0=0 -> DONE at next edge; GATE_EN stays 1 throughout.
REQ-036 IC_OK=0 for at least 3 cycles, request REQ_SEL=1 -> ERR pulse; IS0=0 and GATE_EN=1 unchanged.
REQ-037 IS0=1 and idle, IC_OK dropped at edge F -> IS0=0 at F+2+QUIESCE_CYCLES; FAIL=1; no DONE; a REQ_VALID held in that window is not accepted.
REQ-038 RST asserted at E0+6 of the REQ-034 sequence -> next edge: IS0=0, GATE_EN=1, BUSY=0; REQ_READY=1.
REQ-039 Random REQ_VALID/REQ_SEL/IC_OK stimulus -> assertions hold for REQ-030 and REQ-031; BUSY high exactly QUIESCE_CYCLES+SETTLE_CYCLES cycles per switch.
